// File: rtl/ray_dispatcher.sv
// Frame-level primary ray source: walks a W x H image in raster order, stepping ray directions
// incrementally, and feeds one ray at a time to a single ray unit over its start/busy handshake.
module ray_dispatcher #(
  parameter int unsigned POSITION_WIDTH = 16,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DIM_WIDTH      = 11
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               frameStart,
  input  logic [DIM_WIDTH-1:0]               frameWidth,
  input  logic [DIM_WIDTH-1:0]               frameHeight,
  input  logic [ADDRESS_WIDTH-1:0]           frameBase,
  input  logic [2:0][POSITION_WIDTH-1:0]     cameraQ,
  input  logic [2:0][POSITION_WIDTH-1:0]     cornerV,
  input  logic [2:0][POSITION_WIDTH-1:0]     rightStep,
  input  logic [2:0][POSITION_WIDTH-1:0]     downStep,
  output logic                               frameBusy,
  output logic                               frameDone,
  output logic                               start,
  input  logic                               unitBusy,
  output logic [2:0][POSITION_WIDTH-1:0]     rayQ,
  output logic [2:0][POSITION_WIDTH-1:0]     rayV,
  output logic [ADDRESS_WIDTH-1:0]           pixelAddress
);

  typedef logic [2:0][POSITION_WIDTH-1:0] vec_t;

  typedef enum logic [1:0] {StIdle, StIssue, StSettle, StDone} state_e;

  function automatic vec_t vadd(input vec_t a, input vec_t b);
    vec_t r;
    for (int i = 0; i < 3; i++) r[i] = a[i] + b[i];
    return r;
  endfunction

  state_e                   state_q;
  logic [DIM_WIDTH-1:0]     width_q, height_q, x_q, y_q;
  logic [DIM_WIDTH-1:0]     x_last, y_last;
  vec_t                     right_q, down_q, row_q, cur_q, cam_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     busy_q, done_q;

  assign x_last = width_q - DIM_WIDTH'(1);
  assign y_last = height_q - DIM_WIDTH'(1);

  // The issue pulse is decoded so the ray unit sees it in the same cycle busy is observed low.
  assign start        = (state_q == StIssue) && !unitBusy && !flush;
  assign frameBusy    = busy_q;
  assign frameDone    = done_q;
  assign rayQ         = cam_q;
  assign rayV         = cur_q;
  assign pixelAddress = addr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      width_q  <= '0;
      height_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      right_q  <= '0;
      down_q   <= '0;
      row_q    <= '0;
      cur_q    <= '0;
      cam_q    <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (frameStart) begin
            width_q  <= frameWidth;
            height_q <= frameHeight;
            x_q      <= '0;
            y_q      <= '0;
            right_q  <= rightStep;
            down_q   <= downStep;
            row_q    <= cornerV;
            cur_q    <= cornerV;
            cam_q    <= cameraQ;
            addr_q   <= frameBase;
            if (frameWidth == '0 || frameHeight == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
              busy_q  <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (!unitBusy) state_q <= StSettle;
        end
        StSettle: begin
          if (x_q != x_last) begin
            x_q     <= x_q + DIM_WIDTH'(1);
            cur_q   <= vadd(cur_q, right_q);
            addr_q  <= addr_q + ADDRESS_WIDTH'(1);
            state_q <= StIssue;
          end else if (y_q != y_last) begin
            x_q     <= '0;
            y_q     <= y_q + DIM_WIDTH'(1);
            row_q   <= vadd(row_q, down_q);
            cur_q   <= vadd(row_q, down_q);
            addr_q  <= addr_q + ADDRESS_WIDTH'(1);
            state_q <= StIssue;
          end else begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Scoreboard bench for ray_dispatcher: stimulus pushes expected rays and frameDone times,
// a negedge monitor pops and compares whenever start or frameDone is presented.
module tb_ray_dispatcher;
  localparam int PW = 16;
  localparam int AW = 32;
  localparam int DW = 11;

  typedef logic [2:0][PW-1:0] vec_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    vec_t          v;
    vec_t          q;
  } ray_t;

  logic          clock = 1'b0, reset = 1'b1, flush = 1'b0, frameStart = 1'b0, unitBusy = 1'b0;
  logic [DW-1:0] frameWidth = '0, frameHeight = '0;
  logic [AW-1:0] frameBase = '0;
  vec_t          cameraQ = '0, cornerV = '0, rightStep = '0, downStep = '0;
  logic          frameBusy, frameDone, start;
  vec_t          rayQ, rayV;
  logic [AW-1:0] pixelAddress;

  ray_dispatcher dut (
    .clock(clock), .reset(reset), .flush(flush), .frameStart(frameStart),
    .frameWidth(frameWidth), .frameHeight(frameHeight), .frameBase(frameBase),
    .cameraQ(cameraQ), .cornerV(cornerV), .rightStep(rightStep), .downStep(downStep),
    .frameBusy(frameBusy), .frameDone(frameDone), .start(start), .unitBusy(unitBusy),
    .rayQ(rayQ), .rayV(rayV), .pixelAddress(pixelAddress)
  );

  always #5 clock = ~clock;

  // Sampled at a negedge, cyc equals the index of the next rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  ray_t ray_q[$];
  int   done_q[$];
  int   checks = 0, passes = 0, starts_seen = 0;
  logic seen_start = 1'b0;
  bit   busy_mode = 1'b0;
  int   busy_cnt = 0;
  ray_t e_ray;
  int   e_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    seen_start = start & ~reset;
    if (!reset) begin
      if (start) begin
        starts_seen++;
        chk("ray pending", 64'(ray_q.size() != 0), 64'd1);
        if (ray_q.size() != 0) begin
          e_ray = ray_q.pop_front();
          chk("pixelAddress", 64'(pixelAddress), 64'(e_ray.addr));
          chk("rayV", 64'(rayV), 64'(e_ray.v));
          chk("rayQ", 64'(rayQ), 64'(e_ray.q));
        end
      end
      if (frameDone) begin
        chk("frameDone expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) begin
          e_done = done_q.pop_front();
          if (e_done >= 0) chk("frameDone cycle", 64'(cyc), 64'(e_done));
        end
      end
    end
  end

  // Ray unit model: raises busy the cycle after start and holds it 5 cycles.
  always @(posedge clock) begin
    #1;
    if (busy_mode) begin
      if (seen_start) busy_cnt = 5;
      unitBusy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end else begin
      busy_cnt = 0;
      unitBusy = 1'b0;
    end
  end

  task automatic start_frame(input int w, input int h, input logic [AW-1:0] base,
                             input vec_t corner, input vec_t right, input vec_t down,
                             input vec_t cam, input int max_rays, input bit timed);
    int   n, k;
    ray_t r;
    @(negedge clock);
    n = cyc;
    k = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (k < max_rays) begin
          for (int i = 0; i < 3; i++) r.v[i] = PW'(corner[i] + x * right[i] + y * down[i]);
          r.addr = base + AW'(y * w + x);
          r.q    = cam;
          ray_q.push_back(r);
        end
        k++;
      end
    end
    if (w == 0 || h == 0) done_q.push_back(n + 1);
    else if (max_rays >= w * h) done_q.push_back(timed ? n + 2 * w * h + 1 : -1);
    frameWidth  = DW'(w);
    frameHeight = DW'(h);
    frameBase   = base;
    cornerV     = corner;
    rightStep   = right;
    downStep    = down;
    cameraQ     = cam;
    frameStart  = 1'b1;
    @(posedge clock);
    #1 frameStart = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((ray_q.size() != 0 || done_q.size() != 0) && k < budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("scoreboard drained", 64'(ray_q.size() + done_q.size()), 64'd0);
    chk("frameBusy idle", 64'(frameBusy), 64'd0);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k = 0;
    while (starts_seen < target && k < budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("start reached", 64'(starts_seen >= target), 64'd1);
  endtask

  vec_t cam = {16'd7, 16'd6, 16'd5};
  vec_t c0  = {16'h0100, 16'h0000, 16'h0000};
  vec_t rx  = {16'd0, 16'd0, 16'd1};
  vec_t dy  = {16'd0, 16'd1, 16'd0};
  vec_t cw  = {16'h0000, 16'h0000, 16'hFFFF};
  vec_t z   = '0;

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset start", 64'(start), 64'd0);
    chk("reset frameBusy", 64'(frameBusy), 64'd0);
    chk("reset frameDone", 64'(frameDone), 64'd0);
    chk("reset rayQ", 64'(rayQ), 64'd0);
    chk("reset rayV", 64'(rayV), 64'd0);
    chk("reset pixelAddress", 64'(pixelAddress), 64'd0);

    // 2x2, unitBusy low: frameDone 9 cycles after frameStart
    start_frame(2, 2, 32'h1000, c0, rx, dy, cam, 100, 1'b1);
    @(negedge clock);
    chk("frameBusy in frame", 64'(frameBusy), 64'd1);
    wait_drain(100);

    // same frame with the ray unit busy after every start
    busy_mode = 1'b1;
    start_frame(2, 2, 32'h1000, c0, rx, dy, cam, 100, 1'b0);
    wait_drain(200);
    busy_mode = 1'b0;

    // 3x1 with x component wrapping
    start_frame(3, 1, 32'h0020, cw, rx, z, cam, 100, 1'b1);
    wait_drain(100);

    // zero width: no rays, done one cycle later
    start_frame(0, 4, 32'h3000, c0, rx, dy, cam, 100, 1'b1);
    wait_drain(20);

    // frameStart while busy must be ignored
    start_frame(2, 2, 32'h2000, c0, rx, dy, cam, 100, 1'b1);
    repeat (3) @(negedge clock);
    frameBase   = 32'h9000;
    frameWidth  = 11'd1;
    frameHeight = 11'd1;
    frameStart  = 1'b1;
    @(posedge clock);
    #1 frameStart = 1'b0;
    wait_drain(100);

    // 4x4 flushed after the third ray, then restarted
    start_frame(4, 4, 32'h4000, c0, rx, dy, cam, 3, 1'b1);
    wait_starts(starts_seen + 3, 50);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    chk("flush frameBusy", 64'(frameBusy), 64'd0);
    chk("flush start", 64'(start), 64'd0);
    repeat (6) @(negedge clock);
    wait_drain(10);
    start_frame(2, 1, 32'h4000, c0, rx, dy, cam, 100, 1'b1);
    wait_drain(50);

    // asynchronous reset while start is high
    start_frame(2, 2, 32'h5000, c0, rx, dy, cam, 100, 1'b1);
    wait_starts(starts_seen + 1, 20);
    #1 reset = 1'b1;
    #1;
    chk("async reset start", 64'(start), 64'd0);
    chk("async reset frameBusy", 64'(frameBusy), 64'd0);
    chk("async reset frameDone", 64'(frameDone), 64'd0);
    chk("async reset rayQ", 64'(rayQ), 64'd0);
    chk("async reset rayV", 64'(rayV), 64'd0);
    chk("async reset pixelAddress", 64'(pixelAddress), 64'd0);
    ray_q.delete();
    done_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    start_frame(1, 1, 32'h6000, c0, rx, dy, cam, 100, 1'b1);
    wait_drain(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ray_dispatcher.md
# ray_dispatcher

Frame-level ray source sitting directly upstream of a single ray unit. On a frame start it walks every pixel of a W×H image in raster order, computes each primary ray incrementally from latched camera parameters, and hands it to the ray unit with the unit's `start`/`busy` handshake together with that pixel's framebuffer address. It reports frame progress to the top-level controller and accepts a flush that aborts the frame.

## Interface

Parameters:
- POSITION_WIDTH, 16, width of each ray/camera vector component (two's complement, fixed point)
- ADDRESS_WIDTH, 32, framebuffer address width
- DIM_WIDTH, 11, width of image width/height and pixel counters

Ports:
- clock  input  1  single system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- flush  input  1  synchronous abort of the current frame
- frameStart  input  1  pulse; begins a frame when idle
- frameWidth, frameHeight  input  DIM_WIDTH  image dimensions, sampled at frameStart
- frameBase  input  ADDRESS_WIDTH  address of pixel (0,0), sampled at frameStart
- cameraQ  input  POSITION_WIDTH ×3  ray origin, sampled at frameStart
- cornerV  input  POSITION_WIDTH ×3  direction of pixel (0,0), sampled at frameStart
- rightStep  input  POSITION_WIDTH ×3  direction delta per +1 in x, sampled at frameStart
- downStep  input  POSITION_WIDTH ×3  direction delta per +1 in y, sampled at frameStart
- frameBusy  output  1  high from accepted frameStart until frame completes or aborts
- frameDone  output  1  one-cycle pulse when the last ray of a frame has been issued
- start  output  1  to ray unit; one-cycle issue pulse
- unitBusy  input  1  from ray unit's `busy`
- rayQ, rayV  output  POSITION_WIDTH ×3  ray to ray unit, valid while start is high
- pixelAddress  output  ADDRESS_WIDTH  pixel address to ray unit, valid while start is high

## Operation

- States: IDLE, ISSUE, SETTLE, DONE.
- IDLE: frameStart=1 latches all sampled inputs, x=y=0, rowV=curV=cornerV, addr=frameBase. If frameWidth==0 or frameHeight==0 → DONE, else → ISSUE. frameStart in any other state is ignored.
- ISSUE: while unitBusy=1, hold (start=0). When unitBusy=0, drive start=1 for exactly that cycle with rayQ=cameraQ, rayV=curV, pixelAddress=addr; → SETTLE.
- SETTLE: one cycle; unitBusy is ignored here (ray unit raises busy the cycle after start). Advance: if x<W−1: x+=1, curV+=rightStep, addr+=1 → ISSUE. Else if y<H−1: x=0, y+=1, rowV+=downStep, curV=rowV+downStep, addr+=1 → ISSUE. Else → DONE.
- DONE: frameDone=1 for one cycle, frameBusy drops in same cycle; → IDLE.
- Vector adds are per-component modulo 2^POSITION_WIDTH (wrap, no saturation). addr += 1 modulo 2^ADDRESS_WIDTH. Address is linear: frameBase + y·W + x.
- flush=1 in any state: → IDLE next cycle, start=0 that cycle, no frameDone. flush has priority over frameStart.
- rayQ/rayV/pixelAddress are registered; hold last values outside start cycles (verification checks them only while start=1).

## Timing

- Reset values: start=0, frameBusy=0, frameDone=0, rayQ=rayV=0, pixelAddress=0; state IDLE, counters 0.
- frameStart at edge n → frameBusy=1 from n+1; first start earliest at n+1 (unitBusy low).
- With unitBusy stuck low, one ray issued every 2 cycles; W×H frame: frameDone at cycle n+2·W·H+1 relative to frameStart edge n.
- Zero-dimension frame: frameDone at n+1, no start pulses.
- Reset asserted mid-frame: outputs return to reset values immediately; no frameDone.

## Test plan

- 2×2 frame, base 0x1000, cornerV=(0,0,0x100), rightStep=(1,0,0), downStep=(0,1,0), unitBusy low → four start pulses with addr 0x1000..0x1003, rayV (0,0,0x100),(1,0,0x100),(0,1,0x100),(1,1,0x100); frameDone at cycle 9 after frameStart.
- Same frame, unitBusy driven high 5 cycles after each start → each subsequent start waits for unitBusy low; no duplicate issues; order and values unchanged.
- 3×1 frame, cornerV.x=0xFFFF, rightStep.x=1 → rayV.x sequence 0xFFFF, 0x0000, 0x0001 (wrap).
- frameWidth=0, frameHeight=4 → no start, frameDone one cycle after frameStart; frameStart during busy frame ignored.
- 4×4 frame, flush after third start → IDLE next cycle, frameBusy low, no frameDone; new frameStart restarts at addr=frameBase.
- Reset asserted asynchronously mid-frame (between edges) → start/frameBusy low before next edge, all outputs at reset values.
